fetch_rr_sched: RTL and testbench

- Dual-grant round-robin warp scheduler directly upstream of the fetch stage.
- Each cycle it picks up to two distinct warps among 8 and drives one-hot grants GRT_raw_1_RR_IF / GRT_raw_2_RR_IF. Fetch uses these to select warp PCs and start instruction-cache reads.
- It tracks per-warp instruction-buffer credits so that it never over-fetches into a full per-warp buffer.
- It resets a warp's credits when that warp's PC is redirected.

---
 rtl/fetch_rr_sched_if.sv | 21 ++
 rtl/fetch_rr_sched.sv | 112 +++++++++++
 tb/tb_fetch_rr_sched.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_rr_sched_if.sv
// Scheduler-facing bundle: warp status in from CTA/IBuffer/fetch, registered grants out to fetch.
// Grants carry no ready: a grant is a one-cycle pulse that fetch must accept; flow control comes from per-warp credits returned via IBuf_Pop_IB_RR.
interface fetch_rr_sched_if;
  logic [7:0] WarpActive_CTA_RR;
  logic       Stall_IF_RR;
  logic [7:0] Flush_Warp_IF_RR;
  logic [7:0] IBuf_Pop_IB_RR;
  logic [7:0] GRT_raw_1_RR_IF;
  logic [7:0] GRT_raw_2_RR_IF;
  logic [7:0] Credit_Empty_RR;

  modport master (
    output WarpActive_CTA_RR, Stall_IF_RR, Flush_Warp_IF_RR, IBuf_Pop_IB_RR,
    input  GRT_raw_1_RR_IF, GRT_raw_2_RR_IF, Credit_Empty_RR
  );

  modport slave (
    input  WarpActive_CTA_RR, Stall_IF_RR, Flush_Warp_IF_RR, IBuf_Pop_IB_RR,
    output GRT_raw_1_RR_IF, GRT_raw_2_RR_IF, Credit_Empty_RR
  );
endinterface

// File: rtl/fetch_rr_sched.sv
// Dual-grant round-robin warp scheduler feeding fetch, with per-warp instruction-buffer credits.
// ptr and credit[] are the observable scheduler state; grants appear one cycle after selection.
module fetch_rr_sched #(
  parameter  int IB_DEPTH = 4,
  localparam int CW       = $clog2(IB_DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  fetch_rr_sched_if.slave bus
);

  localparam logic [CW-1:0] FULL = CW'(IB_DEPTH);

  logic [7:0]    active, flush, pop;
  logic          stall;
  logic [2:0]    ptr, ptr_next;
  logic [CW-1:0] credit      [8];
  logic [CW-1:0] credit_next [8];
  logic [7:0]    g1, g2, g1_next, g2_next, granted_now;
  logic [7:0]    empty, empty_next, elig, full_mask;
  logic [2:0]    first_idx, second_idx, idx;
  logic          first_found, second_found;
  logic [CW:0]   sum;

  assign active = bus.WarpActive_CTA_RR;
  assign flush  = bus.Flush_Warp_IF_RR;
  assign pop    = bus.IBuf_Pop_IB_RR;
  assign stall  = bus.Stall_IF_RR;

  assign bus.GRT_raw_1_RR_IF = g1;
  assign bus.GRT_raw_2_RR_IF = g2;
  assign bus.Credit_Empty_RR = empty;

  always_comb begin
    elig      = '0;
    full_mask = '0;
    for (int i = 0; i < 8; i++) begin
      elig[i]      = active[i] && (credit[i] != '0) && !flush[i];
      full_mask[i] = (credit[i] == FULL);
    end
  end

  // Scan from ptr with wrap; the second hit after first is the next eligible warp past first.
  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    idx          = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (elig[idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    g1_next  = '0;
    g2_next  = '0;
    ptr_next = ptr;
    if (!stall) begin
      if (first_found)  g1_next = 8'b1 << first_idx;
      if (second_found) g2_next = 8'b1 << second_idx;
      if (second_found)     ptr_next = second_idx + 3'd1;
      else if (first_found) ptr_next = first_idx + 3'd1;
    end
    granted_now = g1_next | g2_next;
  end

  // A redirect refills the credits; otherwise grant consumes and pop returns, saturating at full.
  always_comb begin
    sum        = '0;
    empty_next = '0;
    for (int i = 0; i < 8; i++) begin
      sum = {1'b0, credit[i]} + {{CW{1'b0}}, pop[i]} - {{CW{1'b0}}, granted_now[i]};
      if (flush[i])
        credit_next[i] = FULL;
      else if (sum > {1'b0, FULL})
        credit_next[i] = FULL;
      else
        credit_next[i] = sum[CW-1:0];
      empty_next[i] = (credit_next[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      g1    <= '0;
      g2    <= '0;
      empty <= '0;
      for (int i = 0; i < 8; i++) credit[i] <= FULL;
    end else begin
      ptr   <= ptr_next;
      g1    <= g1_next;
      g2    <= g2_next;
      empty <= empty_next;
      for (int i = 0; i < 8; i++) credit[i] <= credit_next[i];
    end
  end

  pop_when_full: assert property (@(posedge clk) disable iff (rst)
    (pop & full_mask & ~flush) == 8'h00);

endmodule

// File: tb/tb_fetch_rr_sched.sv
// Directed bench for fetch_rr_sched: one task per scenario with hand-computed expectations.
module tb_fetch_rr_sched;
  localparam int IB = 4;
  localparam int CW = $clog2(IB + 1);
  localparam logic [CW-1:0] FULL = CW'(IB);
  localparam logic [CW-1:0] ZERO = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];

  fetch_rr_sched_if bus();

  fetch_rr_sched #(.IB_DEPTH(IB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] act, input logic stall,
                       input logic [7:0] flush, input logic [7:0] pop);
    bus.WarpActive_CTA_RR = act;
    bus.Stall_IF_RR       = stall;
    bus.Flush_Warp_IF_RR  = flush;
    bus.IBuf_Pop_IB_RR    = pop;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h00) begin
      errors++; $display("FAIL reset_g1: got %h expected 00", bus.GRT_raw_1_RR_IF);
    end
    checks++;
    if (bus.GRT_raw_2_RR_IF !== 8'h00) begin
      errors++; $display("FAIL reset_g2: got %h expected 00", bus.GRT_raw_2_RR_IF);
    end
    checks++;
    if (bus.Credit_Empty_RR !== 8'h00) begin
      errors++; $display("FAIL reset_empty: got %h expected 00", bus.Credit_Empty_RR);
    end
    checks++;
    if (dut.ptr !== 3'd0) begin
      errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.credit[i] !== FULL) begin
        errors++; $display("FAIL reset_credit%0d: got %0d expected %0d", i, dut.credit[i], FULL);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0]  one;
    logic [7:0]  e1;
    logic [15:0] exp;
    one = 8'h01;
    do_reset();
    drive(8'hFF, 1'b0, 8'h00, 8'h00);
    for (int t = 0; t < 16; t++) begin
      e1 = one << (2 * (t % 4));
      exp_q.push_back({e1, e1 << 1});
    end
    exp_q.push_back(16'h0000);
    for (int t = 1; t <= 17; t++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF} !== exp) begin
        errors++;
        $display("FAIL rr_grant cycle %0d: got %h/%h expected %h/%h", t,
                 bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF, exp[15:8], exp[7:0]);
      end
      if (t == 15) begin
        checks++;
        if (bus.Credit_Empty_RR !== 8'h3F) begin
          errors++; $display("FAIL rr_empty15: got %h expected 3f", bus.Credit_Empty_RR);
        end
      end
      if (t == 16) begin
        checks++;
        if (bus.Credit_Empty_RR !== 8'hFF) begin
          errors++; $display("FAIL rr_empty16: got %h expected ff", bus.Credit_Empty_RR);
        end
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (dut.credit[i] !== ZERO) begin
            errors++; $display("FAIL rr_credit%0d: got %0d expected 0", i, dut.credit[i]);
          end
        end
      end
    end
    checks++;
    if (bus.Credit_Empty_RR !== 8'hFF) begin
      errors++; $display("FAIL rr_empty17: got %h expected ff", bus.Credit_Empty_RR);
    end
    checks++;
    if (dut.ptr !== 3'd0) begin
      errors++; $display("FAIL rr_ptr: got %0d expected 0", dut.ptr);
    end
  endtask

  task automatic test_single_warp_pop();
    do_reset();
    drive(8'h20, 1'b0, 8'h00, 8'h00);
    tick();
    drive(8'h20, 1'b0, 8'h00, 8'h20);
    for (int t = 1; t <= 6; t++) begin
      checks++;
      if (bus.GRT_raw_1_RR_IF !== 8'h20 || bus.GRT_raw_2_RR_IF !== 8'h00) begin
        errors++;
        $display("FAIL pop_grant cycle %0d: got %h/%h expected 20/00", t,
                 bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF);
      end
      checks++;
      if (dut.credit[5] !== CW'(3)) begin
        errors++; $display("FAIL pop_credit5 cycle %0d: got %0d expected 3", t, dut.credit[5]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(8'h40, 1'b0, 8'h00, 8'h00);
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h40 || dut.ptr !== 3'd7) begin
      errors++;
      $display("FAIL wrap_setup: got g1=%h ptr=%0d expected g1=40 ptr=7",
               bus.GRT_raw_1_RR_IF, dut.ptr);
    end
    drive(8'h42, 1'b0, 8'h00, 8'h00);
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h02) begin
      errors++; $display("FAIL wrap_g1: got %h expected 02", bus.GRT_raw_1_RR_IF);
    end
    checks++;
    if (bus.GRT_raw_2_RR_IF !== 8'h40) begin
      errors++; $display("FAIL wrap_g2: got %h expected 40", bus.GRT_raw_2_RR_IF);
    end
    checks++;
    if (dut.ptr !== 3'd7) begin
      errors++; $display("FAIL wrap_ptr: got %0d expected 7", dut.ptr);
    end
    checks++;
    if (dut.credit[6] !== CW'(2) || dut.credit[1] !== CW'(3)) begin
      errors++;
      $display("FAIL wrap_credit: got c6=%0d c1=%0d expected c6=2 c1=3",
               dut.credit[6], dut.credit[1]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(8'h04, 1'b0, 8'h00, 8'h00);
    repeat (4) tick();
    checks++;
    if (dut.credit[2] !== ZERO) begin
      errors++; $display("FAIL flush_drain: got %0d expected 0", dut.credit[2]);
    end
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h00 || bus.Credit_Empty_RR !== 8'h04) begin
      errors++;
      $display("FAIL flush_starved: got g1=%h empty=%h expected g1=00 empty=04",
               bus.GRT_raw_1_RR_IF, bus.Credit_Empty_RR);
    end
    drive(8'h04, 1'b0, 8'h04, 8'h04);
    tick();
    checks++;
    if (dut.credit[2] !== FULL) begin
      errors++; $display("FAIL flush_credit: got %0d expected %0d", dut.credit[2], FULL);
    end
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h00 || bus.Credit_Empty_RR !== 8'h00) begin
      errors++;
      $display("FAIL flush_nogrant: got g1=%h empty=%h expected g1=00 empty=00",
               bus.GRT_raw_1_RR_IF, bus.Credit_Empty_RR);
    end
    drive(8'h04, 1'b0, 8'h00, 8'h00);
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h04 || dut.credit[2] !== CW'(3)) begin
      errors++;
      $display("FAIL flush_regrant: got g1=%h c2=%0d expected g1=04 c2=3",
               bus.GRT_raw_1_RR_IF, dut.credit[2]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(8'hFF, 1'b0, 8'h00, 8'h00);
    tick();
    drive(8'hFF, 1'b1, 8'h00, 8'h00);
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (bus.GRT_raw_1_RR_IF !== 8'h00 || bus.GRT_raw_2_RR_IF !== 8'h00) begin
        errors++;
        $display("FAIL stall_grant cycle %0d: got %h/%h expected 00/00", t,
                 bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF);
      end
      checks++;
      if (dut.ptr !== 3'd2 || dut.credit[0] !== CW'(3) || dut.credit[2] !== FULL) begin
        errors++;
        $display("FAIL stall_state cycle %0d: got ptr=%0d c0=%0d c2=%0d expected 2/3/4", t,
                 dut.ptr, dut.credit[0], dut.credit[2]);
      end
    end
    drive(8'hFF, 1'b0, 8'h00, 8'h00);
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h04 || bus.GRT_raw_2_RR_IF !== 8'h08) begin
      errors++;
      $display("FAIL stall_resume: got %h/%h expected 04/08",
               bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF);
    end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    drive(8'hFF, 1'b0, 8'h00, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h00 || bus.GRT_raw_2_RR_IF !== 8'h00) begin
      errors++;
      $display("FAIL midrst_grant: got %h/%h expected 00/00",
               bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF);
    end
    checks++;
    if (dut.ptr !== 3'd0 || bus.Credit_Empty_RR !== 8'h00) begin
      errors++;
      $display("FAIL midrst_ptr: got ptr=%0d empty=%h expected 0/00", dut.ptr, bus.Credit_Empty_RR);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.credit[i] !== FULL) begin
        errors++; $display("FAIL midrst_credit%0d: got %0d expected %0d", i, dut.credit[i], FULL);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.GRT_raw_1_RR_IF !== 8'h01 || bus.GRT_raw_2_RR_IF !== 8'h02) begin
      errors++;
      $display("FAIL midrst_restart: got %h/%h expected 01/02",
               bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF);
    end
  endtask

  initial begin
    drive(8'h00, 1'b0, 8'h00, 8'h00);
    test_reset();
    test_round_robin();
    test_single_warp_pop();
    test_wrap();
    test_flush();
    test_stall();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
